rf_reader: RTL and testbench
============================

# rf_reader

Sequential read-out engine for the 32-entry register file. On a `start` pulse it sweeps a programmed address range through the register file's read port and streams each word out over a valid/ready handshake, flagging the final word. The register file is written by the datapath; this block is the reader on the other end, used for state dumps, debug and context save.

## Interface
Parameters:
- `W`, 32, data width; matches the register file width.
- `A`, 5, address width; 2^A entries.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `first`  in  A  first address of the sweep; sampled with `start`.
- `last`  in  A  last address of the sweep, inclusive; sampled with `start`.
- `rd_addr`  out  A  address to register file read port (`Read1`).
- `rd_data`  in  W  data from register file (`Data1`); asynchronous read, valid in the same cycle as `rd_addr`.
- `out_data`  out  W  streamed word.
- `out_addr`  out  A  address the current `out_data` came from.
- `out_valid`  out  1  `out_data`/`out_addr`/`out_last` valid.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_last`  out  1  current word is the one read from `last`.
- `busy`  out  1  sweep in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse at sweep end.
- `checksum`  out  W  running XOR of streamed words (see Configuration).

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE: `start`=1 and `first`≤`last` → latch `first` into `addr`, latch `last`, → FETCH. `start`=1 and `first`>`last` → DONE (zero words streamed). Otherwise remain.
- FETCH: `rd_addr`=`addr`; at edge register `rd_data` into `out_data`, `addr` into `out_addr`, set `out_last` = (`addr`==latched `last`) → SEND.
- SEND: `out_valid`=1. On `out_valid && out_ready`: if `out_last` → DONE, else `addr`←`addr`+1 → FETCH. Without `out_ready`: hold all outputs stable.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` while `busy` is ignored; `first`/`last` changes during a sweep have no effect.
- `addr` increment is A-bit; because `last` ≤ 2^A−1 and the sweep stops at `last`, wrap-around never occurs. `first`=`last`=31 streams one word.
- `rd_addr` outside FETCH holds the last driven value (0 after reset).
- Writes to the register file during a sweep are legal; the word captured is whatever `rd_data` shows in that word's FETCH cycle.

## Timing
- Reset values: state IDLE, `rd_addr`=0, `out_data`=0, `out_addr`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `checksum`=0.
- `start` at cycle t → FETCH at t+1 → first `out_valid` at t+2.
- Per word: 1 FETCH cycle + ≥1 SEND cycle; peak throughput 1 word / 2 cycles with `out_ready` held high.
- Final handshake at cycle h → `done`=1 at h+1, `busy`=0 and new `start` accepted at h+2.
- `first`>`last`: `start` at t → `done` at t+1, no `out_valid`.
- `reset` asserted in any state: outputs at reset values on the next edge; in-flight word dropped, no `done`.

## Configuration
- `RF_READER_CHECKSUM_EN` defined: `checksum` cleared when a sweep is accepted from IDLE; XORed with `out_data` on every handshake; final value stable from `done` until the next accepted `start` or `reset`.
- Not defined: no checksum register; `checksum` tied to 0.

## Test plan
- Preload reg1=A5A5A5A5, reg2=5A5A5A5A; start first=1,last=2, `out_ready`=1 → two words A5A5A5A5 (addr 1, last=0), 5A5A5A5A (addr 2, last=1), `done` 1 cycle after second handshake; checksum FFFFFFFF when enabled.
- first=last=31, reg31=12345678 → exactly one word, `out_last`=1, `out_addr`=31.
- Backpressure: `out_ready` low 3 cycles in SEND → `out_valid` stays 1, `out_data` unchanged; handshake on 4th cycle, stream continues.
- first=5,last=3 → `done` next cycle, `out_valid` never asserts, `busy` 1 cycle.
- `start` pulsed mid-sweep with different range → ignored; original range completes.
- `reset` during SEND of range 0..7 → next cycle all outputs at reset values, no `done`; new start 0..0 completes normally.

Source files
------------

// File: rtl/rf_reader.sv
// rf_reader: sweeps an address range of the register file read port and
// streams each word over a valid/ready handshake, flagging the final word.
// Optional feature macro: RF_READER_CHECKSUM_EN (running XOR of streamed words).
`timescale 1ns/1ps
module rf_reader #(
  parameter int unsigned W = 32,
  parameter int unsigned A = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] first,
  input  logic [A-1:0] last,
  output logic [A-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic [W-1:0] out_data,
  output logic [A-1:0] out_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [A-1:0]   last_q, last_d;
  logic [A-1:0]   rd_addr_q, rd_addr_d;
  logic [A-1:0]   out_addr_q, out_addr_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_last_q, out_last_d;

  // Next-state and datapath capture for the sweep FSM
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    rd_addr_d  = rd_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (first <= last) begin
            addr_d  = first;
            last_d  = last;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        rd_addr_d  = addr_q;
        out_data_d = rd_data;
        out_addr_d = addr_q;
        out_last_d = (addr_q == last_q);
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      rd_addr_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      rd_addr_q  <= rd_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  // Read port is driven live during FETCH (async RF read); otherwise it
  // holds the last address presented.
  assign rd_addr   = (state_q == S_FETCH) ? addr_q : rd_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign out_valid = (state_q == S_SEND);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

`ifdef RF_READER_CHECKSUM_EN
  logic [W-1:0] checksum_q, checksum_d;
  logic         accept;
  logic         hs;

  assign accept = (state_q == S_IDLE) && start;
  assign hs     = (state_q == S_SEND) && out_ready;

  // Clear on an accepted start, fold in each word as it is handed off
  always_comb begin
    checksum_d = checksum_q;
    if (accept) begin
      checksum_d = '0;
    end else if (hs) begin
      checksum_d = checksum_q ^ out_data_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rf_reader.sv
// Self-checking bench for rf_reader: register-file model drives rd_data,
// expected words are queued at start and compared as the stream emerges.
`timescale 1ns/1ps
module tb_rf_reader;
  localparam int unsigned W = 32;
  localparam int unsigned A = 5;
`ifdef RF_READER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, out_ready;
  logic [A-1:0] first, last, rd_addr, out_addr;
  logic [W-1:0] rd_data, out_data, checksum;
  logic         out_valid, out_last, busy, done;

  logic [W-1:0] rf [32];
  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  rf_reader #(.W(W), .A(A)) dut (
    .clk(clk), .reset(reset), .start(start), .first(first), .last(last),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
  );

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_chk = '0;

  function automatic logic [W-1:0] exp_cs();
    return CHK_EN ? exp_chk : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start request and queue the words it should produce
  task automatic do_start(input int f, input int l);
    start   = 1'b1;
    first   = A'(f);
    last    = A'(l);
    exp_chk = '0;
    if (f <= l) begin
      for (int a = f; a <= l; a++) begin
        sb.push_back('{addr: A'(a), data: rf[a], last: (a == l)});
      end
    end
    tick();
    start = 1'b0;
    first = A'($urandom);
    last  = A'($urandom);
  endtask

  // Consume the stream, stalling `stall` cycles per word, until done
  task automatic drain(input int unsigned stall, input string tag);
    int unsigned cyc = 0;
    int unsigned left = stall;
    bit fin = 1'b0, prev_stall = 1'b0, want_done = 1'b0;
    exp_t e;
    logic [W-1:0] cs_at_done;
    while (!fin) begin
      if (cyc >= 400) begin
        checks++; errors++;
        $display("FAIL %s_timeout: no done after %0d cycles (required done=1)", tag, cyc);
        out_ready = 1'b0;
        return;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s_stall_valid: out_valid=%b required 1", tag, out_valid);
        end
      end
      if (want_done) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL %s_done_timing: done=%b required 1 one cycle after last handshake", tag, done);
        end
      end
      prev_stall = 1'b0;
      want_done  = 1'b0;
      if (done === 1'b1) begin
        out_ready = 1'b0;
        fin = 1'b1;
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL %s_words: %0d words still expected at done, required 0", tag, sb.size());
        end
        checks++;
        if (checksum !== exp_cs()) begin
          errors++;
          $display("FAIL %s_checksum: got %h required %h", tag, checksum, exp_cs());
        end
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_extra: unexpected word addr=%0d data=%h", tag, out_addr, out_data);
          out_ready = 1'b1;
        end else begin
          e = sb[0];
          checks++;
          if ({out_addr, out_data, out_last} !== e) begin
            errors++;
            $display("FAIL %s_word: got addr=%0d data=%h last=%b required addr=%0d data=%h last=%b",
                     tag, out_addr, out_data, out_last, e.addr, e.data, e.last);
          end
          if (left > 0) begin
            out_ready  = 1'b0;
            left--;
            prev_stall = 1'b1;
          end else begin
            out_ready = 1'b1;
            void'(sb.pop_front());
            exp_chk   = exp_chk ^ e.data;
            left      = stall;
            want_done = e.last;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (!fin) begin
        tick();
        cyc++;
      end
    end
    cs_at_done = exp_cs();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b required 0 0", tag, done, busy);
    end
    checks++;
    if (checksum !== cs_at_done) begin
      errors++;
      $display("FAIL %s_cs_hold: got %h required %h", tag, checksum, cs_at_done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({rd_addr, out_data, out_addr, out_valid, out_last, busy, done, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_vals: rd_addr=%0d data=%h addr=%0d v=%b l=%b busy=%b done=%b cs=%h required all 0",
               rd_addr, out_data, out_addr, out_valid, out_last, busy, done, checksum);
    end
  endtask

  task automatic test_basic();
    rf[1] = 32'hA5A5A5A5;
    rf[2] = 32'h5A5A5A5A;
    out_ready = 1'b1;
    do_start(1, 2);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rd_addr !== 5'd1) begin
      errors++;
      $display("FAIL basic_fetch: busy=%b valid=%b rd_addr=%0d required 1 0 1", busy, out_valid, rd_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b required 1 two cycles after start", out_valid);
    end
    drain(0, "basic");
    checks++;
    if (CHK_EN && checksum !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL basic_cs_value: got %h required FFFFFFFF", checksum);
    end
  endtask

  task automatic test_last31();
    rf[31] = 32'h12345678;
    do_start(31, 31);
    drain(0, "last31");
  endtask

  task automatic test_backpressure();
    do_start(8, 11);
    drain(3, "bp");
  endtask

  task automatic test_empty();
    do_start(5, 3);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || checksum !== '0) begin
      errors++;
      $display("FAIL empty_done: done=%b busy=%b valid=%b cs=%h required 1 1 0 0", done, busy, out_valid, checksum);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: done=%b busy=%b valid=%b required 0 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_ignore_start();
    do_start(4, 6);
    start = 1'b1;
    first = 5'd10;
    last  = 5'd12;
    tick();
    start = 1'b0;
    drain(1, "ignore");
  endtask

  task automatic test_reset_mid();
    int unsigned n = 0;
    do_start(0, 7);
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_send: out_valid=%b required 1 before reset", out_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    checks++;
    if ({rd_addr, out_data, out_addr, out_valid, out_last, busy, done, checksum} !== '0) begin
      errors++;
      $display("FAIL rstmid_vals: rd_addr=%0d data=%h addr=%0d v=%b l=%b busy=%b done=%b cs=%h required all 0",
               rd_addr, out_data, out_addr, out_valid, out_last, busy, done, checksum);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nodone: done=%b busy=%b required 0 0", done, busy);
      end
    end
    do_start(0, 0);
    drain(0, "rstmid_new");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; first = '0; last = '0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_last31();
    test_backpressure();
    test_empty();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
